// File: rtl/pwls_reg_bus_bridge_if.sv
// Command-stream and peripheral register-bus bundle for pwls_reg_bus_bridge.
// The master modport is the bridge side; the slave modport is the front end
// together with the peripheral.
interface pwls_reg_bus_bridge_if #(
    parameter int DATA_BITS  = 13,
    parameter int CMD_BITS   = 3,
    parameter int ADDR_BITS  = 6,
    parameter int DATA_SHIFT = 0
);
    localparam int PB = DATA_BITS + DATA_SHIFT;

    logic [CMD_BITS+DATA_BITS-1:0] cmd_in;
    logic                          cmd_valid;
    logic                          cmd_ready;
    logic [ADDR_BITS-1:0]          periph_address;
    logic [PB-1:0]                 periph_data_in;
    logic [1:0]                    periph_data_write_n;
    logic [1:0]                    periph_data_read_n;
    logic [PB-1:0]                 periph_data_out;
    logic                          periph_data_ready;
    logic [DATA_BITS-1:0]          rdata;
    logic                          rdata_valid;
    logic                          err;

    modport master (
        input  cmd_in, cmd_valid, periph_data_out, periph_data_ready,
        output cmd_ready, periph_address, periph_data_in,
        output periph_data_write_n, periph_data_read_n,
        output rdata, rdata_valid, err
    );

    modport slave (
        output cmd_in, cmd_valid, periph_data_out, periph_data_ready,
        input  cmd_ready, periph_address, periph_data_in,
        input  periph_data_write_n, periph_data_read_n,
        input  rdata, rdata_valid, err
    );
endinterface

// File: rtl/pwls_reg_bus_bridge.sv
// Bridge from packed {opcode, payload} command words to register-bus
// write strobes and timed-out reads on a pwl_synth-style peripheral port.
// Ports: clk, reset (sync, active-high), bus (master modport):
//   cmd_in/cmd_valid/cmd_ready   command handshake
//   periph_*                     peripheral address, data, strobes, ready
//   rdata/rdata_valid/err        read return and sticky timeout flag
// Optional: define PWLS_BRIDGE_AUTOINC_EN to post-increment the address
// after WRITE/WRITE_IMM/READ whose payload MSB is set.
module pwls_reg_bus_bridge #(
    parameter int DATA_BITS      = 13,
    parameter int CMD_BITS       = 3,
    parameter int ADDR_BITS      = 6,
    parameter int DATA_SHIFT     = 0,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    pwls_reg_bus_bridge_if.master    bus
);
    localparam int PB = DATA_BITS + DATA_SHIFT;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] OP_CLR_ERR   = 3'd1;
    localparam logic [2:0] OP_WRITE_IMM = 3'd2;
    localparam logic [2:0] OP_SET_ADDR  = 3'd4;
    localparam logic [2:0] OP_SET_DATA  = 3'd5;
    localparam logic [2:0] OP_WRITE     = 3'd6;
    localparam logic [2:0] OP_READ      = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD
    } state_t;

    state_t               state_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] data_q;
    logic [DATA_BITS-1:0] rdata_q;
    logic                 rdata_valid_q;
    logic                 err_q;
    logic [1:0]           write_n_q;
    logic [1:0]           read_n_q;
    logic [7:0]           cnt_q;

    logic [2:0]           opcode;
    logic [DATA_BITS-1:0] payload;
    logic                 accept;
    logic                 done_d;

    // Opcode always comes from the top three bits of the command word.
    assign opcode  = bus.cmd_in[CMD_BITS+DATA_BITS-1 -: 3];
    assign payload = bus.cmd_in[DATA_BITS-1:0];
    assign accept  = bus.cmd_valid && (state_q == S_IDLE);

    // A transaction ends after its single WR cycle, or in RD on ready/timeout.
    assign done_d = (state_q == S_WR) ||
                    ((state_q == S_RD) &&
                     (bus.periph_data_ready || (cnt_q == TO_LAST)));

`ifdef PWLS_BRIDGE_AUTOINC_EN
    logic                 inc_q;
    logic [ADDR_BITS-1:0] addr_inc_d;

    assign addr_inc_d = addr_q + ADDR_BITS'(1);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            data_q        <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
            write_n_q     <= 2'b11;
            read_n_q      <= 2'b11;
            cnt_q         <= '0;
`ifdef PWLS_BRIDGE_AUTOINC_EN
            inc_q         <= 1'b0;
`endif
        end else begin
            rdata_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        case (opcode)
                            OP_CLR_ERR:  err_q  <= 1'b0;
                            OP_SET_ADDR: addr_q <= payload[ADDR_BITS-1:0];
                            OP_SET_DATA: data_q <= payload;
                            OP_WRITE: begin
                                write_n_q <= 2'b10;
                                state_q   <= S_WR;
                            end
                            OP_WRITE_IMM: begin
                                data_q    <= payload;
                                write_n_q <= 2'b10;
                                state_q   <= S_WR;
                            end
                            OP_READ: begin
                                read_n_q <= 2'b10;
                                cnt_q    <= '0;
                                state_q  <= S_RD;
                            end
                            default: ;
                        endcase
                    end
                end
                S_WR: begin
                    write_n_q <= 2'b11;
                    state_q   <= S_IDLE;
                end
                S_RD: begin
                    if (bus.periph_data_ready) begin
                        rdata_q       <= bus.periph_data_out[PB-1:DATA_SHIFT];
                        rdata_valid_q <= 1'b1;
                        read_n_q      <= 2'b11;
                        state_q       <= S_IDLE;
                    end else if (cnt_q == TO_LAST) begin
                        rdata_q       <= '1;
                        err_q         <= 1'b1;
                        rdata_valid_q <= 1'b1;
                        read_n_q      <= 2'b11;
                        state_q       <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    write_n_q <= 2'b11;
                    read_n_q  <= 2'b11;
                    state_q   <= S_IDLE;
                end
            endcase
`ifdef PWLS_BRIDGE_AUTOINC_EN
            // Flag is captured on every accept but only consumed when a
            // WR/RD transaction finishes, so other opcodes never see it.
            if (accept)
                inc_q <= payload[DATA_BITS-1];
            if (done_d && inc_q)
                addr_q <= addr_inc_d;
`endif
        end
    end

`ifndef PWLS_BRIDGE_AUTOINC_EN
    logic unused_done;
    assign unused_done = done_d;
`endif

    assign bus.cmd_ready           = (state_q == S_IDLE);
    assign bus.periph_address      = addr_q;
    assign bus.periph_data_in      = PB'(data_q) << DATA_SHIFT;
    assign bus.periph_data_write_n = write_n_q;
    assign bus.periph_data_read_n  = read_n_q;
    assign bus.rdata               = rdata_q;
    assign bus.rdata_valid         = rdata_valid_q;
    assign bus.err                 = err_q;
endmodule

// File: tb/tb_pwls_reg_bus_bridge.sv
// Scoreboard bench for pwls_reg_bus_bridge: directed scenarios plus random
// command streams against a transaction-level reference model.
module tb_pwls_reg_bus_bridge;
    localparam int DB = 13;
    localparam int CB = 3;
    localparam int AB = 6;
    localparam int DS = 0;
    localparam int TO = 15;
    localparam int PB = DB + DS;

    typedef struct { int unsigned addr; int unsigned data; } wr_t;
    typedef struct { int unsigned rdata; int unsigned err; } rd_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    pwls_reg_bus_bridge_if #(.DATA_BITS(DB), .CMD_BITS(CB),
                             .ADDR_BITS(AB), .DATA_SHIFT(DS)) bus ();

    pwls_reg_bus_bridge #(.DATA_BITS(DB), .CMD_BITS(CB), .ADDR_BITS(AB),
                          .DATA_SHIFT(DS), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 0;

    wr_t exp_wr[$];
    rd_t exp_rd[$];
    int  exp_len[$];

    int unsigned m_addr = 0;
    int unsigned m_data = 0;
    int unsigned m_err  = 0;

    int          rd_delay = 0;
    logic [PB-1:0] rd_word = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: applies one accepted command at transaction level.
    task automatic model(input int op, input int unsigned pl,
                         input int d, input int unsigned word);
        bit inc = 0;
        case (op)
            1: m_err = 0;
            4: m_addr = pl % (1 << AB);
            5: m_data = pl;
            2, 6: begin
                if (op == 2) m_data = pl;
                exp_wr.push_back('{m_addr, m_data});
                inc = 1;
            end
            7: begin
                rd_t r;
                if (d < TO) begin
                    exp_len.push_back(d + 1);
                    r.rdata = (word >> DS) % (1 << DB);
                end else begin
                    exp_len.push_back(TO);
                    r.rdata = (1 << DB) - 1;
                    m_err = 1;
                end
                r.err = m_err;
                exp_rd.push_back(r);
                inc = 1;
            end
            default: ;
        endcase
`ifdef PWLS_BRIDGE_AUTOINC_EN
        if (inc && pl[DB-1]) m_addr = (m_addr + 1) % (1 << AB);
`else
        if (inc) m_addr = m_addr;
`endif
    endtask

    task automatic send(input int op, input int unsigned pl,
                        input int d, input int unsigned word);
        int waited = 0;
        @(negedge clk);
        while (!bus.cmd_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.cmd_ready) begin
            chk("ready_wait", 32'(bus.cmd_ready), 32'd1);
            return;
        end
        bus.cmd_in    = {3'(op), DB'(pl)};
        bus.cmd_valid = 1'b1;
        if (op == 7) begin
            rd_delay = d;
            rd_word  = PB'(word);
        end
        model(op, pl % (1 << DB), d, word);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_in    = (CB + DB)'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) chk("idle_wait", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"},   32'(bus.cmd_ready), 32'd1);
        chk({tag, "_addr"},    32'(bus.periph_address), 32'd0);
        chk({tag, "_din"},     32'(bus.periph_data_in), 32'd0);
        chk({tag, "_wr_n"},    32'(bus.periph_data_write_n), 32'd3);
        chk({tag, "_rd_n"},    32'(bus.periph_data_read_n), 32'd3);
        chk({tag, "_rdata"},   32'(bus.rdata), 32'd0);
        chk({tag, "_rvalid"},  32'(bus.rdata_valid), 32'd0);
        chk({tag, "_err"},     32'(bus.err), 32'd0);
    endtask

    // Peripheral: answers reads after rd_delay cycles, noisy when idle.
    initial begin
        int idx = 0;
        bus.periph_data_ready = 1'b0;
        bus.periph_data_out   = '0;
        forever begin
            @(negedge clk);
            if (bus.periph_data_read_n == 2'b10) begin
                bus.periph_data_ready = (idx == rd_delay);
                bus.periph_data_out   = rd_word;
                idx++;
            end else begin
                idx = 0;
                bus.periph_data_ready = 1'($urandom);
                bus.periph_data_out   = PB'($urandom);
            end
        end
    end

    // Monitor: pops scoreboard entries as the DUT presents events.
    initial begin
        bit   prev_w = 0;
        int   rlen = 0;
        logic [AB-1:0] raddr = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                bit w;
                bit r;
                w = (bus.periph_data_write_n == 2'b10);
                r = (bus.periph_data_read_n == 2'b10);
                if (w) begin
                    chk("strobe_excl", 32'(r), 32'd0);
                    chk("wr_ready_low", 32'(bus.cmd_ready), 32'd0);
                    if (prev_w) chk("wr_one_cycle", 32'(prev_w), 32'd0);
                    if (exp_wr.size() == 0) begin
                        chk("wr_unexpected", 32'd1, 32'd0);
                    end else begin
                        wr_t e;
                        e = exp_wr.pop_front();
                        chk("wr_addr", 32'(bus.periph_address), e.addr);
                        chk("wr_data", 32'(bus.periph_data_in),
                            e.data << DS);
                    end
                end else if (prev_w) begin
                    chk("wr_ready_back", 32'(bus.cmd_ready), 32'd1);
                end
                if (r) begin
                    if (rlen == 0) raddr = bus.periph_address;
                    else chk("rd_addr_stable", 32'(bus.periph_address),
                             32'(raddr));
                    rlen++;
                end else if (rlen > 0) begin
                    if (exp_len.size() == 0)
                        chk("rd_len_unexpected", 32'(rlen), 32'd0);
                    else
                        chk("rd_len", 32'(rlen), 32'(exp_len.pop_front()));
                    rlen = 0;
                end
                if (bus.rdata_valid) begin
                    if (exp_rd.size() == 0) begin
                        chk("rvalid_unexpected", 32'd1, 32'd0);
                    end else begin
                        rd_t e;
                        e = exp_rd.pop_front();
                        chk("rdata", 32'(bus.rdata), e.rdata);
                        chk("rd_err", 32'(bus.err), e.err);
                    end
                end
                prev_w = w;
            end else begin
                prev_w = 0;
                rlen = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_in    = '0;
        bus.cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1;

        // Basic write
        send(4, 5, 0, 0);
        send(5, 'h1ABC, 0, 0);
        send(6, 0, 0, 0);
        wait_idle();
        chk("bw_addr", 32'(bus.periph_address), 32'd5);

        // Read with a 4-cycle wait
        send(4, 3, 0, 0);
        send(7, 0, 3, 'h0123);
        wait_idle();
        chk("rd_rdata", 32'(bus.rdata), 32'h123);
        chk("rd_err0", 32'(bus.err), 32'd0);

        // Timeout, sticky error, clear
        send(7, 0, 100, 0);
        wait_idle();
        chk("to_rdata", 32'(bus.rdata), 32'h1FFF);
        chk("to_err", 32'(bus.err), 32'd1);
        send(7, 0, 2, 'h0777);
        wait_idle();
        chk("to_sticky", 32'(bus.err), 32'd1);
        send(1, 0, 0, 0);
        wait_idle();
        chk("clr_err", 32'(bus.err), 32'd0);

        // Command presented while busy is dropped
        send(6, 0, 0, 0);
        @(negedge clk);
        chk("busy_ready", 32'(bus.cmd_ready), 32'd0);
        bus.cmd_in    = {3'd4, DB'(9)};
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        wait_idle();
        chk("busy_addr", 32'(bus.periph_address), 32'd3);

        // Reset two cycles into a read
        send(4, 12, 0, 0);
        send(5, 'h0F0F, 0, 0);
        send(7, 0, 50, 0);
        @(negedge clk);
        @(negedge clk);
        void'(exp_rd.pop_back());
        void'(exp_len.pop_back());
        exp_len.push_back(2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_vals("mid");
        m_addr = 0;
        m_data = 0;
        m_err  = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Address wrap through auto-increment
        send(4, 63, 0, 0);
        send(2, 'h1055, 0, 0);
        wait_idle();
`ifdef PWLS_BRIDGE_AUTOINC_EN
        chk("ai_addr", 32'(bus.periph_address), 32'd0);
`else
        chk("ai_addr", 32'(bus.periph_address), 32'd63);
`endif

        // Random command stream
        for (int i = 0; i < 400; i++) begin
            int op;
            int unsigned pl;
            op = int'($urandom_range(0, 7));
            pl = $urandom % (1 << DB);
            send(op, pl, int'($urandom_range(0, 19)), $urandom);
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        chk("end_wr_q", 32'(exp_wr.size()), 32'd0);
        chk("end_rd_q", 32'(exp_rd.size()), 32'd0);
        chk("end_len_q", 32'(exp_len.size()), 32'd0);
        chk("end_addr", 32'(bus.periph_address), m_addr);
        chk("end_din", 32'(bus.periph_data_in), m_data << DS);
        chk("end_err", 32'(bus.err), m_err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
